// File: rtl/accumulation_pkg.sv
// Shared types and helpers for the streaming accumulator: state encoding,
// accumulator sizing and the saturating narrowing used on the final sum.
package accumulation_pkg;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic signed [31:0] value;
    logic               overflow;
  } sat_t;

  localparam int ENC_POS_ONE = 1;
  localparam int ENC_NEG_ONE = -1;

  // Wide enough for +/- in_cnt * 2^in_bit, the worst-case vector sum.
  function automatic int acc_width(input int in_cnt, input int in_bit);
    return $clog2(in_cnt * (2 ** in_bit)) + 1;
  endfunction

  function automatic sat_t sat_to(input int out_bit, input int value);
    sat_t r;
    int   hi;
    int   lo;
    hi = (2 ** (out_bit - 1)) - 1;
    lo = -(2 ** (out_bit - 1));
    r.overflow = 1'b0;
    r.value    = value;
    if (value > hi) begin
      r.value    = hi;
      r.overflow = 1'b1;
    end else if (value < lo) begin
      r.value    = lo;
      r.overflow = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/accumulation_lane_sum.sv
// Combinational masked adder tree: sums the first valid_cnt lanes of one beat,
// each sign-extended to the accumulator width; lanes beyond valid_cnt add zero.
module accumulation_lane_sum #(
  parameter int PARAM_LANE_CNT = 16,
  parameter int PARAM_IN_BIT   = 2,
  parameter int PARAM_ACC_W    = 13
) (
  input  logic [PARAM_LANE_CNT-1:0][PARAM_IN_BIT:0]  value,
  input  logic [$clog2(PARAM_LANE_CNT+1)-1:0]        valid_cnt,
  output logic signed [PARAM_ACC_W-1:0]              sum
);

  localparam int LEAVES = 1 << $clog2(PARAM_LANE_CNT);

  logic signed [PARAM_ACC_W-1:0] node [1:2*LEAVES-1];

  // Leaves sit at LEAVES..2*LEAVES-1, padded to a power of two; node k sums 2k and 2k+1.
  always_comb begin
    node = '{default: '0};
    for (int i = 0; i < PARAM_LANE_CNT; i++) begin
      if (i < int'(valid_cnt)) begin
        node[LEAVES+i] = PARAM_ACC_W'(signed'(value[i]));
      end
    end
    for (int k = LEAVES - 1; k >= 1; k--) begin
      node[k] = node[2*k] + node[2*k+1];
    end
  end

  assign sum = node[1];

endmodule

// File: rtl/accumulation_stream_sat.sv
// Streaming vector accumulator: sums a multi-beat vector of signed partial
// products and emits one saturated or sign-binarised result per vector.
module accumulation_stream_sat
  import accumulation_pkg::*;
#(
  parameter int PARAM_IN_CNT   = 784,
  parameter int PARAM_IN_BIT   = 2,
  parameter int PARAM_LANE_CNT = 16,
  parameter int PARAM_OUT_BIT  = 2
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       in_valid_i,
  output logic                                       in_ready_o,
  input  logic [PARAM_LANE_CNT-1:0][PARAM_IN_BIT:0]  value_i,
  input  logic                                       mode_i,
  output logic                                       out_valid_o,
  input  logic                                       out_ready_i,
  output logic [PARAM_OUT_BIT-1:0]                   result_o,
  output logic                                       overflow_o,
  output logic                                       busy_o
);

  localparam int PARAM_BEAT_CNT = (PARAM_IN_CNT + PARAM_LANE_CNT - 1) / PARAM_LANE_CNT;
  localparam int PARAM_ACC_W    = acc_width(PARAM_IN_CNT, PARAM_IN_BIT);
  localparam int LAST_LANES     = PARAM_IN_CNT - (PARAM_BEAT_CNT - 1) * PARAM_LANE_CNT;
  localparam int BEAT_W         = (PARAM_BEAT_CNT > 1) ? $clog2(PARAM_BEAT_CNT) : 1;
  localparam int CNT_W          = $clog2(PARAM_LANE_CNT + 1);

  state_t                        state;
  logic signed [PARAM_ACC_W-1:0] acc;
  logic signed [PARAM_ACC_W-1:0] lane_sum;
  logic signed [PARAM_ACC_W-1:0] final_sum;
  logic [BEAT_W-1:0]             beat_cnt;
  logic                          mode_q;
  logic                          first_beat;
  logic                          last_beat;
  logic                          eff_mode;
  logic                          accept;
  logic [CNT_W-1:0]              valid_lanes;
  sat_t                          sat_res;
  logic [PARAM_OUT_BIT-1:0]      result_next;
  logic                          overflow_next;

  assign in_ready_o  = (state == ACC) && !rst_i;
  assign out_valid_o = (state == HOLD);
  assign busy_o      = (beat_cnt != '0) || (state == HOLD);
  assign accept      = in_valid_i && in_ready_o;
  assign first_beat  = (beat_cnt == '0);
  assign last_beat   = (beat_cnt == BEAT_W'(PARAM_BEAT_CNT - 1));
  assign valid_lanes = last_beat ? CNT_W'(LAST_LANES) : CNT_W'(PARAM_LANE_CNT);
  // The first beat's mode takes effect immediately, before it is latched.
  assign eff_mode    = first_beat ? mode_i : mode_q;
  assign final_sum   = acc + lane_sum;
  assign sat_res     = sat_to(PARAM_OUT_BIT, int'(final_sum));

  accumulation_lane_sum #(
    .PARAM_LANE_CNT (PARAM_LANE_CNT),
    .PARAM_IN_BIT   (PARAM_IN_BIT),
    .PARAM_ACC_W    (PARAM_ACC_W)
  ) u_lane_sum (
    .value     (value_i),
    .valid_cnt (valid_lanes),
    .sum       (lane_sum)
  );

  always_comb begin
    result_next   = PARAM_OUT_BIT'(sat_res.value);
    overflow_next = sat_res.overflow;
    if (eff_mode) begin
      result_next   = final_sum[PARAM_ACC_W-1] ? PARAM_OUT_BIT'(ENC_NEG_ONE)
                                               : PARAM_OUT_BIT'(ENC_POS_ONE);
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ACC;
      acc        <= '0;
      beat_cnt   <= '0;
      mode_q     <= 1'b0;
      result_o   <= '0;
      overflow_o <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            if (first_beat) begin
              mode_q <= mode_i;
            end
            if (last_beat) begin
              acc        <= '0;
              beat_cnt   <= '0;
              result_o   <= result_next;
              overflow_o <= overflow_next;
              state      <= HOLD;
            end else begin
              acc      <= final_sum;
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            state <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_accumulation_stream_sat.sv
// Self-checking bench for accumulation_stream_sat: directed vectors with literal
// expectations plus randomized traffic checked every cycle against a sum model.
module tb_accumulation_stream_sat;

  localparam int IN_CNT   = 10;
  localparam int IN_BIT   = 2;
  localparam int LANE_CNT = 4;
  localparam int OUT_BIT  = 2;
  localparam int BEAT_CNT = 3;
  localparam int VW       = IN_BIT + 1;
  localparam int BEAT_BITS = LANE_CNT * VW;

  typedef struct {
    int res;
    int ovf;
  } exp_t;

  logic                             clk_i = 1'b0;
  logic                             rst_i;
  logic                             in_valid_i;
  logic                             in_ready_o;
  logic [LANE_CNT-1:0][IN_BIT:0]    value_i;
  logic                             mode_i;
  logic                             out_valid_o;
  logic                             out_ready_i;
  logic [OUT_BIT-1:0]               result_o;
  logic                             overflow_o;
  logic                             busy_o;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  bit   partial;
  bit   mon_en;
  int   ready_policy;
  int   hold_cnt;
  int   ev[IN_CNT];
  int   w;
  int   n;

  always #5 clk_i = ~clk_i;

  accumulation_stream_sat #(
    .PARAM_IN_CNT   (IN_CNT),
    .PARAM_IN_BIT   (IN_BIT),
    .PARAM_LANE_CNT (LANE_CNT),
    .PARAM_OUT_BIT  (OUT_BIT)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .value_i     (value_i),
    .mode_i      (mode_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .overflow_o  (overflow_o),
    .busy_o      (busy_o)
  );

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Expected output straight from the vector: plain sum, then clamp or sign.
  function automatic exp_t model(input int e[IN_CNT], input bit mode);
    exp_t r;
    int   s;
    int   c;
    s = 0;
    foreach (e[i]) s += e[i];
    r.ovf = 0;
    if (mode) begin
      c = (s >= 0) ? 1 : -1;
    end else begin
      c = s;
      if (s > 1) begin
        c = 1;
        r.ovf = 1;
      end else if (s < -2) begin
        c = -2;
        r.ovf = 1;
      end
    end
    r.res = c & ((1 << OUT_BIT) - 1);
    return r;
  endfunction

  // Per-cycle compare against the pending-result queue.
  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      if (mon_en && !rst_i) begin
        chk("out_valid", int'(out_valid_o), int'(exp_q.size() > 0));
        chk("in_ready", int'(in_ready_o), int'(exp_q.size() == 0));
        chk("busy", int'(busy_o), int'(partial || exp_q.size() > 0));
        if (out_valid_o && exp_q.size() > 0) begin
          chk("result", int'(result_o), exp_q[0].res);
          chk("overflow", int'(overflow_o), exp_q[0].ovf);
          if (out_ready_i) exp_q.delete(0);
        end
      end
    end
  end

  // Downstream ready: always, random, or held low for 3 HOLD cycles.
  initial begin
    out_ready_i = 1'b1;
    hold_cnt    = 0;
    forever begin
      @(negedge clk_i);
      #1;
      case (ready_policy)
        0: begin
          out_ready_i = 1'b1;
          hold_cnt    = 0;
        end
        1: begin
          out_ready_i = 1'($urandom_range(0, 1));
          hold_cnt    = 0;
        end
        default: begin
          out_ready_i = (hold_cnt >= 3);
          hold_cnt    = out_valid_o ? hold_cnt + 1 : 0;
        end
      endcase
    end
  end

  task automatic sendBeat(input logic [LANE_CNT-1:0][IN_BIT:0] v, input logic m,
                          output int waits);
    waits      = 0;
    in_valid_i = 1'b1;
    value_i    = v;
    mode_i     = m;
    #1;
    while (!in_ready_o && waits < 100) begin
      waits++;
      @(negedge clk_i);
      #1;
    end
    if (!in_ready_o) chk("beat_accept_timeout", 0, 1);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic applyStimulus(input int e[IN_CNT], input bit m0, input bit mlater,
                               input int fill, input int gap, output int first_wait);
    logic [LANE_CNT-1:0][IN_BIT:0] v;
    int                            wt;
    int                            idx;
    first_wait = 0;
    for (int b = 0; b < BEAT_CNT; b++) begin
      for (int l = 0; l < LANE_CNT; l++) begin
        idx  = b * LANE_CNT + l;
        v[l] = (idx < IN_CNT) ? VW'(e[idx]) : VW'(fill);
      end
      sendBeat(v, (b == 0) ? m0 : mlater, wt);
      if (b == 0) first_wait = wt;
      if (b < BEAT_CNT - 1) begin
        partial = 1'b1;
        for (int g = 0; g < gap; g++) begin
          in_valid_i = 1'b0;
          value_i    = BEAT_BITS'($urandom);
          mode_i     = 1'($urandom_range(0, 1));
          @(negedge clk_i);
        end
      end
    end
    in_valid_i = 1'b0;
    partial    = 1'b0;
    exp_q.push_back(model(e, m0));
  endtask

  task automatic checkOutput(input string name, input int res, input int ovf);
    #2;
    chk({name, "_valid"}, int'(out_valid_o), 1);
    chk({name, "_result"}, int'(result_o), res);
    chk({name, "_overflow"}, int'(overflow_o), ovf);
    @(negedge clk_i);
  endtask

  task automatic doReset();
    rst_i      = 1'b1;
    in_valid_i = 1'b0;
    #1;
    chk("reset_in_ready_low", int'(in_ready_o), 0);
    @(negedge clk_i);
    rst_i   = 1'b0;
    partial = 1'b0;
    exp_q.delete();
    #1;
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_out_valid", int'(out_valid_o), 0);
    chk("reset_result", int'(result_o), 0);
    chk("reset_overflow", int'(overflow_o), 0);
    chk("reset_in_ready_high", int'(in_ready_o), 1);
    @(negedge clk_i);
  endtask

  initial begin
    rst_i        = 1'b1;
    in_valid_i   = 1'b0;
    value_i      = '0;
    mode_i       = 1'b0;
    ready_policy = 0;
    partial      = 1'b0;
    mon_en       = 1'b0;
    @(negedge clk_i);
    doReset();
    mon_en = 1'b1;

    $display("[TB] masked saturate high");
    foreach (ev[i]) ev[i] = 1;
    applyStimulus(ev, 1'b0, 1'b0, 3, 0, w);
    checkOutput("t1", 1, 1);

    $display("[TB] exact zero");
    foreach (ev[i]) ev[i] = (i % 2 == 0) ? 1 : -1;
    applyStimulus(ev, 1'b0, 1'b0, -4, 0, w);
    checkOutput("t2", 0, 0);

    $display("[TB] saturate low");
    foreach (ev[i]) ev[i] = -4;
    applyStimulus(ev, 1'b0, 1'b0, -4, 0, w);
    checkOutput("t3a", 2, 1);
    foreach (ev[i]) ev[i] = (i < 2) ? -1 : 0;
    applyStimulus(ev, 1'b0, 1'b0, 3, 0, w);
    checkOutput("t3b", 2, 0);

    $display("[TB] sign mode with later mode toggle");
    foreach (ev[i]) ev[i] = (i % 2 == 0) ? 1 : -1;
    applyStimulus(ev, 1'b1, 1'b0, 3, 0, w);
    checkOutput("t4a", 1, 0);
    foreach (ev[i]) ev[i] = (i == 0) ? -1 : 0;
    applyStimulus(ev, 1'b1, 1'b0, -4, 0, w);
    checkOutput("t4b", 3, 0);
    foreach (ev[i]) ev[i] = (i < 5) ? 1 : 0;
    applyStimulus(ev, 1'b1, 1'b0, 3, 0, w);
    checkOutput("t4c", 1, 0);

    $display("[TB] input bubbles and output backpressure");
    foreach (ev[i]) ev[i] = 1;
    applyStimulus(ev, 1'b0, 1'b0, 3, 2, w);
    checkOutput("t5a", 1, 1);
    ready_policy = 2;
    foreach (ev[i]) ev[i] = (i % 2 == 0) ? 1 : -1;
    applyStimulus(ev, 1'b0, 1'b0, 3, 0, w);
    foreach (ev[i]) ev[i] = 1;
    applyStimulus(ev, 1'b1, 1'b1, -4, 0, w);
    chk("t5b_first_beat_wait", w, 4);
    ready_policy = 0;
    checkOutput("t5b", 1, 0);

    $display("[TB] reset mid-vector");
    sendBeat({LANE_CNT{3'(3)}}, 1'b0, w);
    in_valid_i = 1'b0;
    partial    = 1'b1;
    #1;
    chk("t6_busy_mid", int'(busy_o), 1);
    @(negedge clk_i);
    doReset();
    foreach (ev[i]) ev[i] = (i == 0) ? -1 : 0;
    applyStimulus(ev, 1'b0, 1'b0, 3, 0, w);
    checkOutput("t6", 3, 0);

    $display("[TB] randomized traffic");
    ready_policy = 1;
    for (int v = 0; v < 40; v++) begin
      foreach (ev[i]) ev[i] = int'($urandom_range(0, 7)) - 4;
      applyStimulus(ev, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 7)) - 4, int'($urandom_range(0, 2)), w);
    end
    ready_policy = 0;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (exp_q.size() > 0) chk("drain_timeout", int'(exp_q.size()), 0);
    repeat (3) @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
